receiver_rsa_blind: RTL and testbench

Receiver-side blinding stage of the RSA-based 1-out-of-2 oblivious transfer flow. It sits directly upstream of sender_rsa_pack.
- Computes v = (x_b + k^e mod N) mod N from the receiver's choice bit b, the two public random values x0/x1, the RSA public key (N, e) and the receiver's secret k.
- v drives the sender's received_data input.
- Contains its own fixed-latency right-to-left square-and-multiply engine, so latency is constant and independent of operand values.

---
 rtl/receiver_rsa_blind.sv | 136 +++++++++++++
 tb/tb_receiver_rsa_blind.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver_rsa_blind.sv
// -----------------------------------------------------------------------------
// receiver_rsa_blind
//
// Receiver-side blinding stage for the RSA 1-out-of-2 oblivious transfer.
// Computes send_data = (x_b + k^e mod N) mod N.
// The modular exponentiation uses a right-to-left square-and-multiply loop
// that always runs WIDTH cycles, so the latency does not depend on the
// operand values.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   gen        level start request, sampled in IDLE
//   b          choice bit: 0 selects rand_val0, 1 selects rand_val1
//   rand_val0  public random value x0
//   rand_val1  public random value x1
//   N          RSA modulus
//   e          RSA public exponent
//   k          receiver secret
//   send_data  blinded value v, feeds sender_rsa_pack received_data
//   gen_end    high while in DONE; send_data valid
//
// state | meaning
// IDLE  | wait for gen, capture operands on the start edge
// EXP   | one exponent bit per cycle, exactly WIDTH cycles
// ADD   | blind: send_data <= (res + xs) mod N
// DONE  | result valid, gen_end high until gen drops
// -----------------------------------------------------------------------------
module receiver_rsa_blind #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             gen,
    input  logic             b,
    input  logic [WIDTH-1:0] rand_val0,
    input  logic [WIDTH-1:0] rand_val1,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] send_data,
    output logic             gen_end
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] ebuf;
    logic [WIDTH-1:0] xs;
    logic [CW-1:0]    cnt;

    // A zero modulus maps everything to 0 so that N = 0 never divides by zero.
    function automatic logic [WIDTH-1:0] mod_n(input logic [2*WIDTH-1:0] a,
                                               input logic [WIDTH-1:0]   m);
        logic [2*WIDTH-1:0] m_ext;
        m_ext = {{WIDTH{1'b0}}, m};
        if (m == '0)
            return '0;
        return WIDTH'(a % m_ext);
    endfunction

    logic [2*WIDTH-1:0] prod_rb;
    logic [2*WIDTH-1:0] prod_bb;
    logic [WIDTH:0]     sum_rx;
    logic [WIDTH:0]     sum_red;
    logic [WIDTH-1:0]   x_sel;

    assign prod_rb = {{WIDTH{1'b0}}, res}  * {{WIDTH{1'b0}}, base};
    assign prod_bb = {{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base};
    assign x_sel   = b ? rand_val1 : rand_val0;

    // Both addends are already < N, so one conditional subtract suffices.
    assign sum_rx  = {1'b0, res} + {1'b0, xs};
    assign sum_red = (sum_rx >= {1'b0, n_reg}) ? (sum_rx - {1'b0, n_reg}) : sum_rx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            n_reg     <= '0;
            base      <= '0;
            res       <= '0;
            ebuf      <= '0;
            xs        <= '0;
            cnt       <= '0;
            send_data <= '0;
            gen_end   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gen) begin
                        n_reg <= N;
                        base  <= mod_n({{WIDTH{1'b0}}, k}, N);
                        res   <= mod_n({{(2*WIDTH-1){1'b0}}, 1'b1}, N);
                        ebuf  <= e;
                        xs    <= mod_n({{WIDTH{1'b0}}, x_sel}, N);
                        cnt   <= '0;
                        state <= EXP;
                    end
                end
                EXP: begin
                    if (ebuf[0])
                        res <= mod_n(prod_rb, n_reg);
                    base <= mod_n(prod_bb, n_reg);
                    ebuf <= ebuf >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= ADD;
                end
                ADD: begin
                    send_data <= sum_red[WIDTH-1:0];
                    gen_end   <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // No auto-restart: gen must drop before another start.
                    if (!gen) begin
                        gen_end <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_receiver_rsa_blind.sv
// -----------------------------------------------------------------------------
// tb_receiver_rsa_blind
//
// Self-checking bench for receiver_rsa_blind: a table of operand sets with
// expected results, plus hand-written control sequences (1-cycle gen pulse,
// operand changes during EXP, gen held in DONE, asynchronous reset mid-EXP).
// Expected values are pushed to a queue at the start edge and popped when
// gen_end rises.
// -----------------------------------------------------------------------------
module tb_receiver_rsa_blind;

    logic        clk;
    logic        rstn;
    logic        gen;
    logic        b;
    logic [31:0] rand_val0;
    logic [31:0] rand_val1;
    logic [31:0] n_in;
    logic [31:0] e_in;
    logic [31:0] k_in;
    logic [31:0] send_data;
    logic        gen_end;

    receiver_rsa_blind #(.WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .gen       (gen),
        .b         (b),
        .rand_val0 (rand_val0),
        .rand_val1 (rand_val1),
        .N         (n_in),
        .e         (e_in),
        .k         (k_in),
        .send_data (send_data),
        .gen_end   (gen_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        b;
        logic [31:0] x0;
        logic [31:0] x1;
        logic [31:0] n;
        logic [31:0] e;
        logic [31:0] k;
        logic [31:0] expv;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    // Independent reference: left-to-right square-and-multiply.
    function automatic logic [31:0] modexp(input logic [31:0] bs,
                                           input logic [31:0] ex,
                                           input logic [31:0] m);
        logic [63:0] r;
        logic [63:0] bb;
        if (m == 0) return 32'd0;
        r  = 64'd1 % {32'd0, m};
        bb = {32'd0, bs} % {32'd0, m};
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % {32'd0, m};
            if (ex[i]) r = (r * bb) % {32'd0, m};
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] model(input vec_t v);
        logic [63:0] x;
        logic [63:0] s;
        if (v.n == 0) return 32'd0;
        x = {32'd0, (v.b ? v.x1 : v.x0)} % {32'd0, v.n};
        s = (x + {32'd0, modexp(v.k, v.e, v.n)}) % {32'd0, v.n};
        return s[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h), expected %0d", name, act, act, req);
        end
    endtask

    // Drive operands and request a start; the next rising edge is edge 0.
    task automatic start_op(input vec_t v, input logic push);
        b         = v.b;
        rand_val0 = v.x0;
        rand_val1 = v.x1;
        n_in      = v.n;
        e_in      = v.e;
        k_in      = v.k;
        gen       = 1'b1;
        if (push) sb_q.push_back(v.expv);
        @(posedge clk);
        #1;
    endtask

    // Counts edges after edge 0 until gen_end is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!gen_end && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] req;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %0d", name, send_data);
        end else begin
            req = sb_q.pop_front();
            check(name, send_data, req);
        end
    endtask

    // gen_end appears after the ADD edge, which is edge 33 counting from the
    // sampling edge 0 (the 34th edge including the sampling edge).
    localparam int LAT = 33;

    vec_t tbl[12];
    vec_t v;
    int   lat;
    int   hi_cycles;
    logic [31:0] held;

    initial begin
        tbl[0] = '{1'b0, 32'd100,  32'd200,  32'd3233, 32'd17, 32'd65, 32'd2890};
        tbl[1] = '{1'b1, 32'd100,  32'd200,  32'd3233, 32'd17, 32'd65, 32'd2990};
        tbl[2] = '{1'b1, 32'd100,  32'd3000, 32'd3233, 32'd17, 32'd65, 32'd2557};
        tbl[3] = '{1'b0, 32'd3238, 32'd200,  32'd3233, 32'd17, 32'd65, 32'd2795};
        tbl[4] = '{1'b0, 32'd7,    32'd200,  32'd3233, 32'd0,  32'd0,  32'd8};
        tbl[5] = '{1'b0, 32'd100,  32'd200,  32'd3233, 32'd17, 32'd0,  32'd100};
        tbl[6] = '{1'b0, 32'd100,  32'd200,  32'd1,    32'd17, 32'd65, 32'd0};
        tbl[7] = '{1'b1, 32'd100,  32'd200,  32'd0,    32'd17, 32'd65, 32'd0};
        for (int i = 8; i < 12; i++) begin
            tbl[i].b  = 1'($urandom_range(0, 1));
            tbl[i].x0 = $urandom;
            tbl[i].x1 = $urandom;
            tbl[i].n  = $urandom | 32'h8000_0001;
            tbl[i].e  = $urandom;
            tbl[i].k  = $urandom;
            tbl[i].expv = model(tbl[i]);
        end

        rstn = 1'b0; gen = 1'b0; b = 1'b0;
        rand_val0 = '0; rand_val1 = '0; n_in = '0; e_in = '0; k_in = '0;
        #1;
        check("reset_send_data", send_data, 32'd0);
        check("reset_gen_end", {31'd0, gen_end}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Table: gen held high through the run, then dropped.
        for (int i = 0; i < 12; i++) begin
            start_op(tbl[i], 1'b1);
            wait_done(lat);
            check($sformatf("latency_%0d", i), lat, LAT);
            pop_check($sformatf("vec_%0d", i));
            if (i == 1)
                check("cross_check_k", modexp(send_data - 32'd200, 32'd2753, 32'd3233), 32'd65);
            held = send_data;
            gen  = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("gen_end_clear_%0d", i), {31'd0, gen_end}, 32'd0);
            check($sformatf("send_hold_%0d", i), send_data, held);
        end

        // 1-cycle gen pulse: gen_end is a 1-cycle pulse.
        v = tbl[1];
        start_op(v, 1'b1);
        gen = 1'b0;
        wait_done(lat);
        check("pulse_latency", lat, LAT);
        pop_check("pulse_result");
        hi_cycles = 0;
        while (gen_end && hi_cycles < 10) begin
            hi_cycles++;
            @(posedge clk);
            #1;
        end
        check("pulse_width", hi_cycles, 1);

        // Operands changed during EXP must not affect the result.
        v = tbl[0];
        start_op(v, 1'b1);
        b = 1'b1; rand_val0 = 32'd5; rand_val1 = 32'd77;
        n_in = 32'd1234567; e_in = 32'hFFFF_FFFF; k_in = 32'd999;
        @(posedge clk);
        #1;
        wait_done(lat);
        lat++;
        check("change_latency", lat, LAT);
        pop_check("change_result");

        // gen held high in DONE: stays there, no restart.
        held = send_data;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("done_hold_gen_end_%0d", c), {31'd0, gen_end}, 32'd1);
            check($sformatf("done_hold_data_%0d", c), send_data, held);
        end
        gen = 1'b0;
        @(posedge clk);
        #1;
        check("done_exit", {31'd0, gen_end}, 32'd0);

        // Asynchronous reset after edge 10 of EXP (cnt = 10).
        v = tbl[2];
        start_op(v, 1'b0);
        repeat (10) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("abort_send_data", send_data, 32'd0);
        check("abort_gen_end", {31'd0, gen_end}, 32'd0);
        gen = 1'b0;
        @(posedge clk);
        #1;
        check("abort_stay_idle", {31'd0, gen_end}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        start_op(tbl[0], 1'b1);
        wait_done(lat);
        check("post_reset_latency", lat, LAT);
        pop_check("post_reset_result");
        gen = 1'b0;
        @(posedge clk);
        #1;

        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
